// File: rtl/enum_trace_fmt.sv
// Formats one enumerated value per request as an ASCII character stream: its name from a
// parameterised table, or a Verilog-style 'h / 'b literal. Out-of-table values are counted.
module enum_trace_fmt #(
    parameter int W        = 2,
    parameter int NAME_LEN = 10,
    // Entry v char k lives at bits [((v*NAME_LEN)+k)*8 +: 8]. The strings are written
    // reversed so that char 0 ends up in the low byte.
    parameter logic [(2**W)*NAME_LEN*8-1:0] NAME_TABLE =
        {80'h0, "ENOD_ETATS", "YSUB_ETATS", "ELDI_ETATS"}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_val,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_char,
    output logic         out_last,
    output logic [15:0]  unk_cnt
);
    localparam int NE = 2**W;
    localparam int ND = (W + 3) / 4;
    localparam int IW = 5;

    typedef enum logic {IDLE, EMIT} state_t;
    typedef enum logic [1:0] {FMT_NAME, FMT_HEX, FMT_BIN} fmt_t;

    state_t         state_reg;
    logic [W-1:0]   val_reg;
    logic [1:0]     mode_reg;
    logic [IW-1:0]  idx_reg;
    logic [7:0]     char_reg;
    logic           last_reg;
    logic [15:0]    unk_reg;

    logic [7:0]     name_chr  [NE][NAME_LEN];
    logic [IW-1:0]  entry_len [NE];

    function automatic logic [IW-1:0] name_length(input int v);
        logic [IW-1:0] len;
        len = IW'(NAME_LEN);
        for (int k = NAME_LEN - 1; k >= 0; k--) begin
            if (NAME_TABLE[((v * NAME_LEN) + k) * 8 +: 8] == 8'h00) begin
                len = IW'(k);
            end
        end
        return len;
    endfunction

    for (genvar gi = 0; gi < NE; gi++) begin : g_entry
        for (genvar gk = 0; gk < NAME_LEN; gk++) begin : g_chr
            assign name_chr[gi][gk] = NAME_TABLE[((gi * NAME_LEN) + gk) * 8 +: 8];
        end
        assign entry_len[gi] = name_length(gi);
    end

    // The next character is computed from the incoming request while idle, or from the
    // latched request at index+1 while emitting; one path feeds both register loads.
    logic [W-1:0]    sel_val;
    logic [1:0]      sel_mode;
    logic [IW-1:0]   sel_idx;
    logic [IW-1:0]   sel_len;
    logic [IW-1:0]   dig;
    logic [7:0]      sel_char;
    logic [7:0]      name_c;
    logic            sel_last;
    logic            sel_in_enum;
    logic            bit_v;
    logic [3:0]      nib;
    logic [4*ND-1:0] pad_val;
    fmt_t            fmt;

    always_comb begin
        sel_val     = (state_reg == IDLE) ? in_val  : val_reg;
        sel_mode    = (state_reg == IDLE) ? in_mode : mode_reg;
        sel_idx     = (state_reg == IDLE) ? '0 : idx_reg + 1'b1;
        sel_in_enum = (entry_len[sel_val] != '0);
        dig         = sel_idx - IW'(2);
        pad_val     = '0;
        pad_val[W-1:0] = sel_val;
        nib    = 4'h0;
        bit_v  = 1'b0;
        name_c = 8'h00;
        for (int j = 0; j < ND; j++) begin
            if (dig == IW'(j)) nib = pad_val[(ND - 1 - j) * 4 +: 4];
        end
        for (int j = 0; j < W; j++) begin
            if (dig == IW'(j)) bit_v = sel_val[W - 1 - j];
        end
        for (int k = 0; k < NAME_LEN; k++) begin
            if (sel_idx == IW'(k)) name_c = name_chr[sel_val][k];
        end

        if (sel_mode == 2'd2)                     fmt = FMT_BIN;
        else if (sel_mode == 2'd1 || !sel_in_enum) fmt = FMT_HEX;
        else                                      fmt = FMT_NAME;

        sel_len  = entry_len[sel_val];
        sel_char = name_c;
        case (fmt)
            FMT_HEX: begin
                sel_len = IW'(2 + ND);
                if (sel_idx == '0)       sel_char = 8'h27;
                else if (sel_idx == 'd1) sel_char = 8'h68;
                else if (nib < 4'd10)    sel_char = 8'h30 + {4'h0, nib};
                else                     sel_char = 8'h57 + {4'h0, nib};
            end
            FMT_BIN: begin
                sel_len = IW'(2 + W);
                if (sel_idx == '0)       sel_char = 8'h27;
                else if (sel_idx == 'd1) sel_char = 8'h62;
                else                     sel_char = bit_v ? 8'h31 : 8'h30;
            end
            default: ;
        endcase
        sel_last = (sel_idx == sel_len - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            val_reg   <= '0;
            mode_reg  <= '0;
            idx_reg   <= '0;
            char_reg  <= 8'h00;
            last_reg  <= 1'b0;
            unk_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: if (in_valid) begin
                    state_reg <= EMIT;
                    val_reg   <= in_val;
                    mode_reg  <= in_mode;
                    idx_reg   <= '0;
                    char_reg  <= sel_char;
                    last_reg  <= sel_last;
                    if (entry_len[in_val] == '0 && unk_reg != 16'hFFFF) begin
                        unk_reg <= unk_reg + 16'd1;
                    end
                end
                EMIT: if (out_ready) begin
                    if (last_reg) begin
                        state_reg <= IDLE;
                        idx_reg   <= '0;
                        char_reg  <= 8'h00;
                        last_reg  <= 1'b0;
                    end else begin
                        idx_reg   <= sel_idx;
                        char_reg  <= sel_char;
                        last_reg  <= sel_last;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == EMIT);
    assign out_char  = char_reg;
    assign out_last  = last_reg;
    assign unk_cnt   = unk_reg;
endmodule

// File: tb/tb_enum_trace_fmt.sv
// Directed and randomized checks of enum_trace_fmt against a string-level reference model.
module tb_enum_trace_fmt;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_val = '0;
    logic [1:0]   in_mode = 2'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_char;
    logic         out_last;
    logic [15:0]  unk_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int unk_model = 0;
    string names [4] = '{"STATE_IDLE", "STATE_BUSY", "STATE_DONE", ""};

    always #5 clk = ~clk;

    enum_trace_fmt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_val    (in_val),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_last  (out_last),
        .unk_cnt   (unk_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic string expect_str(input int v, input int m);
        logic [W-1:0] vv;
        vv = v[W-1:0];
        if ((m == 0 || m == 3) && names[v].len() > 0) return names[v];
        if (m == 2) return $sformatf("'b%b", vv);
        return $sformatf("'h%h", vv);
    endfunction

    // stall: 0 always ready, 1 ready on every third cycle, 2 random. abort_after>0 stops early.
    task automatic send(input int v, input int m, input int stall, input int abort_after);
        string s;
        int i;
        int cyc;
        s = expect_str(v, m);
        i = 0;
        cyc = 0;
        check("in_ready_before", 32'(in_ready), 32'd1);
        check("out_valid_before", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_val   = W'(v);
        in_mode  = 2'(m);
        if (names[v].len() == 0 && unk_model < 65535) unk_model++;
        @(negedge clk);
        in_valid = 1'b0;
        check("unk_cnt", 32'(unk_cnt), 32'(unk_model));
        while (i < s.len()) begin
            if (abort_after > 0 && i == abort_after) return;
            if (cyc > 200) begin
                check("timeout", 32'(i), 32'(s.len()));
                return;
            end
            case (stall)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (stall != 0) begin
                in_val  = W'($urandom_range(0, 3));
                in_mode = 2'($urandom_range(0, 3));
            end
            check($sformatf("out_valid[%0d]", i), 32'(out_valid), 32'd1);
            check($sformatf("out_char[%0d] v=%0d m=%0d", i, v, m), 32'(out_char), 32'(s[i]));
            check($sformatf("out_last[%0d]", i), 32'(out_last), 32'(i == s.len() - 1));
            if (out_ready) i++;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (stall == 0) check("consecutive_cycles", 32'(cyc), 32'(s.len()));
        check("in_ready_after", 32'(in_ready), 32'd1);
        check("out_valid_after", 32'(out_valid), 32'd0);
        $display("string v=%0d mode=%0d stall=%0d expected \"%s\" in %0d cycles", v, m, stall, s, cyc);
    endtask

    initial begin
        // Reset held two cycles with a request pending
        rst_n = 1'b0; in_valid = 1'b1; in_val = 2'd3; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_unk_cnt", 32'(unk_cnt), 32'd0);
        check("rst_out_char", 32'(out_char), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;

        send(1, 0, 0, 0);
        send(3, 0, 0, 0);
        send(3, 2, 0, 0);
        send(2, 1, 0, 0);
        send(2, 2, 0, 0);
        send(2, 3, 0, 0);
        send(0, 0, 1, 0);
        send(1, 3, 1, 0);

        // Abort mid-string, with a sink handshake offered during reset
        send(0, 0, 0, 4);
        rst_n = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        unk_model = 0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_char", 32'(out_char), 32'd0);
        check("abort_out_last", 32'(out_last), 32'd0);
        check("abort_unk_cnt", 32'(unk_cnt), 32'd0);
        rst_n = 1'b1; out_ready = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        send(0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            send($urandom_range(0, 3), $urandom_range(0, 3), 2, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end
endmodule
